// File: rtl/poker_types.sv
// Shared card encoding and deck constants for the dealing logic.
package poker_types;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  localparam int DECK_SIZE      = 52;
  localparam int CARDS_PER_DEAL = 9;
  localparam int RANK_MIN       = 2;
  localparam int RANK_MAX       = 14;

endpackage

// File: rtl/card_index_decode.sv
// Maps a deck index 0..51 to a card: suit = idx/13, rank = idx%13 + 2 (ace = 14).
// Compare/subtract ladder, no divider. Indices >= 52 give don't-care cards.
module card_index_decode
  import poker_types::*;
(
  input  logic [5:0] idx_i,
  output card_t      card_o
);

  logic [5:0] base;

  always_comb begin
    card_o.suit = 2'd0;
    base        = 6'd0;
    if (idx_i >= 6'd39) begin
      card_o.suit = 2'd3;
      base        = 6'd39;
    end else if (idx_i >= 6'd26) begin
      card_o.suit = 2'd2;
      base        = 6'd26;
    end else if (idx_i >= 6'd13) begin
      card_o.suit = 2'd1;
      base        = 6'd13;
    end
    card_o.rank = 4'(idx_i - base + 6'(RANK_MIN));
  end

endmodule

// File: rtl/card_dealer.sv
// Deals 9 distinct cards by rejection-sampling a free-running Galois LFSR.
// Optional CARD_DEALER_SEED_LOAD_EN adds seed_load/seed_in for replayable deals.
module card_dealer
  import poker_types::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             deal_start,
`ifdef CARD_DEALER_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
`endif
  output logic             deal_busy,
  output logic             deal_done,
  output logic             cards_valid,
  output card_t [1:0]      player1_cards,
  output card_t [1:0]      player2_cards,
  output card_t [2:0]      flop_cards,
  output card_t            turn_card,
  output card_t            river_card
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [51:0] used_q, used_d;
  logic [3:0]  count_q, count_d;
  card_t [8:0] slots_q, slots_d;
  logic        done_q, done_d;

  logic [5:0]  cand_idx;
  logic [51:0] cand_onehot;
  logic        accept;
  card_t       cand_card;
  logic [15:0] lfsr_shift;

  assign cand_idx    = lfsr_q[5:0];
  assign cand_onehot = 52'd1 << cand_idx;
  assign accept      = (cand_idx < 6'(DECK_SIZE)) && ((used_q & cand_onehot) == '0);

  card_index_decode u_decode (
    .idx_i  (cand_idx),
    .card_o (cand_card)
  );

  assign lfsr_shift = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_comb begin
    lfsr_d = (lfsr_q == 16'h0000) ? LFSR_SEED : lfsr_shift;
`ifdef CARD_DEALER_SEED_LOAD_EN
    if (seed_load) lfsr_d = (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    count_d = count_q;
    slots_d = slots_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (deal_start) state_d = CLEAR;
      end
      CLEAR: begin
        used_d  = '0;
        count_d = 4'd0;
        state_d = DRAW;
      end
      DRAW: begin
        if (accept) begin
          used_d           = used_q | cand_onehot;
          slots_d[count_q] = cand_card;
          count_d          = count_q + 4'd1;
          if (count_q == 4'(CARDS_PER_DEAL - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      used_q  <= '0;
      count_q <= 4'd0;
      slots_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      used_q  <= used_d;
      count_q <= count_d;
      slots_q <= slots_d;
      done_q  <= done_d;
    end
  end

  assign deal_busy   = (state_q == CLEAR) || (state_q == DRAW);
  assign cards_valid = (state_q == DONE);
  assign deal_done   = done_q;

  // Slot order follows real dealing order around the table.
  assign player1_cards[0] = slots_q[0];
  assign player2_cards[0] = slots_q[1];
  assign player1_cards[1] = slots_q[2];
  assign player2_cards[1] = slots_q[3];
  assign flop_cards[0]    = slots_q[4];
  assign flop_cards[1]    = slots_q[5];
  assign flop_cards[2]    = slots_q[6];
  assign turn_card        = slots_q[7];
  assign river_card       = slots_q[8];

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: an LFSR reference model predicts every hand into a
// scoreboard at deal_start; results are popped and compared at deal_done.
module tb_card_dealer;
  import poker_types::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef card_t [8:0] hand_t;
  typedef struct packed {
    hand_t cards;
    int    lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        deal_start = 1'b0;
`ifdef CARD_DEALER_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0000;
`endif
  logic        deal_busy, deal_done, cards_valid;
  card_t [1:0] player1_cards, player2_cards;
  card_t [2:0] flop_cards;
  card_t       turn_card, river_card;
  logic [5:0]  dec_idx = 6'd0;
  card_t       dec_card;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m;
  exp_t        sb[$];
  logic [51:0] seen = '0;

  always #5 clk = ~clk;

  card_dealer dut (
    .clk           (clk),
    .reset         (reset),
    .deal_start    (deal_start),
`ifdef CARD_DEALER_SEED_LOAD_EN
    .seed_load     (seed_load),
    .seed_in       (seed_in),
`endif
    .deal_busy     (deal_busy),
    .deal_done     (deal_done),
    .cards_valid   (cards_valid),
    .player1_cards (player1_cards),
    .player2_cards (player2_cards),
    .flop_cards    (flop_cards),
    .turn_card     (turn_card),
    .river_card    (river_card)
  );

  card_index_decode u_dec (.idx_i(dec_idx), .card_o(dec_card));

  function automatic logic [15:0] step(input logic [15:0] v);
    if (v == 16'h0000) return SEED;
    return {1'b0, v[15:1]} ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  // Reference LFSR, tracking what the dealer's LFSR should hold each cycle.
  always @(posedge clk) begin
    if (reset) m <= SEED;
`ifdef CARD_DEALER_SEED_LOAD_EN
    else if (seed_load) m <= (seed_in == 16'h0000) ? SEED : seed_in;
`endif
    else m <= step(m);
  end

  function automatic card_t ref_card(input int idx);
    card_t c;
    c.suit = 2'(idx / 13);
    c.rank = 4'(idx % 13 + 2);
    return c;
  endfunction

  // l0 is the LFSR value in the cycle deal_start is high; draws begin two cycles later.
  function automatic exp_t predict(input logic [15:0] l0);
    exp_t        e;
    logic [15:0] l;
    logic [51:0] used;
    int          k, cyc, idx;
    e.cards = '0;
    e.lat   = -1;
    used    = '0;
    k       = 0;
    l       = step(step(l0));
    cyc     = 2;
    for (int it = 0; it < 70000 && k < 9; it++) begin
      idx = int'(l[5:0]);
      if (idx < 52 && !used[idx]) begin
        used[idx]  = 1'b1;
        e.cards[k] = ref_card(idx);
        k++;
        if (k == 9) e.lat = cyc + 1;
      end
      l = step(l);
      cyc++;
    end
    return e;
  endfunction

  function automatic hand_t get_hand();
    hand_t h;
    h[0] = player1_cards[0];
    h[1] = player2_cards[0];
    h[2] = player1_cards[1];
    h[3] = player2_cards[1];
    h[4] = flop_cards[0];
    h[5] = flop_cards[1];
    h[6] = flop_cards[2];
    h[7] = turn_card;
    h[8] = river_card;
    return h;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_deal(input bit pulse_during, output hand_t h);
    exp_t e;
    int   n, dups, idx;
    h = '0;
    @(negedge clk);
    deal_start = 1'b1;
    sb.push_back(predict(m));
    @(negedge clk);
    deal_start = 1'b0;
    n = 1;
    while (!deal_done && n < 5000) begin
      check("busy_phase", {deal_busy, cards_valid, deal_done}, 3'b100);
      if (pulse_during) deal_start = 1'b1;
      @(negedge clk);
      deal_start = 1'b0;
      n++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    if (!deal_done) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("latency", n, e.lat);
    check("done_flags", {deal_busy, cards_valid}, 2'b01);
    h = get_hand();
    check("hand", h, e.cards);
    dups = 0;
    for (int i = 0; i < 9; i++) begin
      if (h[i].rank < 4'd2 || h[i].rank > 4'd14) dups++;
      for (int j = i + 1; j < 9; j++) if (h[i] == h[j]) dups++;
      idx = int'(h[i].suit) * 13 + int'(h[i].rank) - 2;
      if (idx >= 0 && idx < 52) seen[idx] = 1'b1;
    end
    check("distinct_in_range", dups, 0);
    @(negedge clk);
    check("done_pulse_hold", {deal_busy, cards_valid, deal_done}, 3'b010);
    check("hand_hold", get_hand(), h);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hand_t ha, hb;

    // Decoder corners and the full deck.
    dec_idx = 6'd0;  #1; check("dec_0",  dec_card, 6'b00_0010);
    dec_idx = 6'd12; #1; check("dec_12", dec_card, 6'b00_1110);
    dec_idx = 6'd13; #1; check("dec_13", dec_card, 6'b01_0010);
    dec_idx = 6'd51; #1; check("dec_51", dec_card, 6'b11_1110);
    for (int i = 0; i < 52; i++) begin
      dec_idx = 6'(i);
      #1;
      check("dec_all", dec_card, ref_card(i));
    end

    // Reset values.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_flags", {deal_busy, cards_valid, deal_done}, 3'b000);
    check("reset_cards", get_hand(), '0);

    // Basic deal.
    run_deal(1'b0, ha);

    // Redundant deal_start pulses during a deal versus a clean replay.
    do_reset();
    repeat (3) @(negedge clk);
    run_deal(1'b1, ha);
    do_reset();
    repeat (3) @(negedge clk);
    run_deal(1'b0, hb);
    check("pulse_vs_clean", ha, hb);

    // Reset four cycles into a deal.
    @(negedge clk);
    deal_start = 1'b1;
    sb.push_back(predict(m));
    @(negedge clk);
    deal_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    check("midreset_flags", {deal_busy, cards_valid, deal_done}, 3'b000);
    check("midreset_cards", get_hand(), '0);
    run_deal(1'b0, ha);

`ifdef CARD_DEALER_SEED_LOAD_EN
    // Replayable deals from a loaded seed; zero seed falls back to the default.
    @(negedge clk); seed_in = 16'h1234; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0;
    run_deal(1'b0, ha);
    @(negedge clk); seed_in = 16'h1234; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0;
    run_deal(1'b1, hb);
    check("seed_replay", ha, hb);
    @(negedge clk); seed_in = 16'h0000; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0;
    run_deal(1'b0, ha);
    @(negedge clk); seed_in = SEED; seed_load = 1'b1;
    @(negedge clk); seed_load = 1'b0;
    run_deal(1'b0, hb);
    check("seed_zero_default", ha, hb);
`endif

    // Many back-to-back deals with random gaps.
    for (int d = 0; d < 1000; d++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_deal(1'b0, ha);
    end
    check("all_indices_seen", seen, {52{1'b1}});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
